ct_spsram_8192x128_ctrl: RTL and testbench

Two-requester access controller for one 8192x128 single-port SRAM macro (ct_f_spsram_8192x128 interface: active-low CEN/GWEN/per-bit WEN, 13-bit address, 128-bit data). It owns the macro's only port and arbitrates read and write requests from two clients with round-robin fairness. It returns read data with fixed latency and, optionally, zero-fills the whole array after reset. It sits between the cache-side requesters and the SRAM instance.

---
 rtl/ct_spsram_8192x128_ctrl.sv | 81 ++++++++
 tb/tb_ct_spsram_8192x128_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ct_spsram_8192x128_ctrl.sv
// ct_spsram_8192x128_ctrl: round-robin two-client controller for one 8192x128 single-port SRAM.
// Define CT_SPSRAM_CTRL_INIT_EN to zero-fill the whole array after reset.
module ct_spsram_8192x128_ctrl #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 128
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  p0_req,
  input  logic                  p0_wr,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  input  logic [DATA_WIDTH-1:0] p0_wmask,
  input  logic                  p1_req,
  input  logic                  p1_wr,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  input  logic [DATA_WIDTH-1:0] p1_wmask,
  output logic                  p0_gnt,
  output logic                  p1_gnt,
  output logic                  p0_rvld,
  output logic                  p1_rvld,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic                  ram_cen,
  output logic                  ram_gwen,
  output logic [DATA_WIDTH-1:0] ram_wen,
  output logic [DATA_WIDTH-1:0] ram_d,
  input  logic [DATA_WIDTH-1:0] ram_q
);
  typedef enum logic [1:0] {WAIT, INIT, RUN} state_t;
  state_t state, state_d;
  logic rr, rr_d, gnt, wr, init_wr;
  logic [ADDR_WIDTH-1:0] a_q, cnt;
`ifdef CT_SPSRAM_CTRL_INIT_EN
  logic [ADDR_WIDTH-1:0] cnt_d;
  always_ff @(posedge forever_cpuclk or negedge cpurst_b)
    if (!cpurst_b) cnt <= '0;
    else cnt <= cnt_d;
  always_comb begin
    init_wr = state == INIT;
    cnt_d   = init_wr ? cnt + 1'b1 : '0;
    state_d = state == WAIT ? INIT : state == INIT ? (&cnt ? RUN : INIT) : RUN;
  end
`else
  assign cnt     = '0;
  assign init_wr = 1'b0;
  assign state_d = RUN;
`endif
  // rr=0 favours p0 on contention; it flips to the other client after every grant
  always_comb begin
    p0_gnt   = state == RUN && p0_req && (!p1_req || !rr);
    p1_gnt   = state == RUN && p1_req && !p0_gnt;
    gnt      = p0_gnt | p1_gnt;
    wr       = p0_gnt ? p0_wr : p1_wr;
    rr_d     = gnt ? p0_gnt : rr;
    ram_cen  = !(gnt || init_wr);
    ram_gwen = !(init_wr || (gnt && wr));
    ram_a    = gnt ? (p0_gnt ? p0_addr : p1_addr) : init_wr ? cnt : a_q;
    ram_wen  = gnt && wr ? ~(p0_gnt ? p0_wmask : p1_wmask) : init_wr ? '0 : '1;
    ram_d    = gnt && wr ? (p0_gnt ? p0_wdata : p1_wdata) : '0;
  end
  assign rdata = ram_q;
  always_ff @(posedge forever_cpuclk or negedge cpurst_b)
    if (!cpurst_b) begin
      state     <= WAIT;
      rr        <= 1'b0;
      a_q       <= '0;
      p0_rvld   <= 1'b0;
      p1_rvld   <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state     <= state_d;
      rr        <= rr_d;
      a_q       <= ram_a;
      p0_rvld   <= p0_gnt && !p0_wr;
      p1_rvld   <= p1_gnt && !p1_wr;
      init_done <= state_d == RUN;
    end
endmodule

// File: tb/tb_ct_spsram_8192x128_ctrl.sv
// tb_ct_spsram_8192x128_ctrl: random and directed traffic checked against a cycle-level behavioural model.
// Expectations adapt to CT_SPSRAM_CTRL_INIT_EN when the design is built with it.
module tb_ct_spsram_8192x128_ctrl;
  localparam int AW = 13;
  localparam int DW = 128;
`ifdef CT_SPSRAM_CTRL_INIT_EN
  localparam int RUN_START = 8193;
`else
  localparam int RUN_START = 1;
`endif
  localparam logic [DW-1:0] DEAD = 128'hDEAD_1111_2222_3333_4444_5555_6666_BEEF;
  logic clk = 1'b0, cpurst_b;
  logic p0_req, p0_wr, p1_req, p1_wr;
  logic [AW-1:0] p0_addr, p1_addr, ram_a;
  logic [DW-1:0] p0_wdata, p0_wmask, p1_wdata, p1_wmask, rdata, ram_wen, ram_d, ram_q;
  logic p0_gnt, p1_gnt, p0_rvld, p1_rvld, init_done, ram_cen, ram_gwen;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;

  ct_spsram_8192x128_ctrl dut (
    .forever_cpuclk(clk), .cpurst_b(cpurst_b),
    .p0_req(p0_req), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_wmask(p0_wmask),
    .p1_req(p1_req), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_wmask(p1_wmask),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_rvld(p0_rvld), .p1_rvld(p1_rvld), .rdata(rdata),
    .init_done(init_done), .ram_a(ram_a), .ram_cen(ram_cen), .ram_gwen(ram_gwen),
    .ram_wen(ram_wen), .ram_d(ram_d), .ram_q(ram_q));

  // SRAM macro stand-in
  logic [DW-1:0] mem [2**AW];
  always @(posedge clk)
    if (!ram_cen) begin
      if (!ram_gwen) mem[ram_a] <= (mem[ram_a] & ram_wen) | (ram_d & ~ram_wen);
      else ram_q <= mem[ram_a];
    end

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference model: cycle index since reset release, fairness preference, expected memory image
  int cyc;
  bit pref, ev0, ev1, erk, lak;
  logic [DW-1:0] erd;
  logic [AW-1:0] la;
  logic [DW-1:0] em [2**AW];
  bit kn [2**AW];
  always @(negedge clk) begin
    bit run, e0, e1, w;
    logic [AW-1:0] a;
    logic [DW-1:0] m, d;
    if (!cpurst_b) begin
      chk("rst_p0_rvld", p0_rvld, 0);
      chk("rst_p1_rvld", p1_rvld, 0);
      chk("rst_init_done", init_done, 0);
      chk("rst_cen", ram_cen, 1);
      chk("rst_gwen", ram_gwen, 1);
      chk("rst_wen", ram_wen, '1);
      chk("rst_gnt", {p0_gnt, p1_gnt}, 0);
      cyc = 0; pref = 0; ev0 = 0; ev1 = 0; lak = 0;
    end else begin
      run = cyc >= RUN_START;
      chk("init_done", init_done, run);
      chk("p0_rvld", p0_rvld, ev0);
      chk("p1_rvld", p1_rvld, ev1);
      if ((ev0 || ev1) && erk) chk("rdata", rdata, erd);
      e0 = run && p0_req && (!p1_req || !pref);
      e1 = run && p1_req && !e0;
      chk("p0_gnt", p0_gnt, e0);
      chk("p1_gnt", p1_gnt, e1);
      ev0 = 0; ev1 = 0;
      if (e0 || e1) begin
        w = e0 ? p0_wr : p1_wr;
        a = e0 ? p0_addr : p1_addr;
        m = e0 ? p0_wmask : p1_wmask;
        d = e0 ? p0_wdata : p1_wdata;
        chk("ram_cen", ram_cen, 0);
        chk("ram_a", ram_a, a);
        chk("ram_gwen", ram_gwen, !w);
        chk("ram_wen", ram_wen, w ? ~m : '1);
        if (w) begin
          chk("ram_d", ram_d, d);
          em[a] = (em[a] & ~m) | (d & m);
          kn[a] = kn[a] || (&m);
        end else begin
          ev0 = e0; ev1 = e1; erk = kn[a]; erd = em[a];
        end
        pref = e0; la = a; lak = 1;
      end
`ifdef CT_SPSRAM_CTRL_INIT_EN
      else if (cyc >= 1 && !run) begin
        chk("init_cen", ram_cen, 0);
        chk("init_gwen", ram_gwen, 0);
        chk("init_wen", ram_wen, 0);
        chk("init_d", ram_d, 0);
        chk("init_a", ram_a, cyc - 1);
        em[cyc-1] = '0; kn[cyc-1] = 1; la = AW'(cyc - 1); lak = 1;
      end
`endif
      else begin
        chk("idle_cen", ram_cen, 1);
        if (!run) chk("idle_gwen", ram_gwen, 1);
        if (!run) chk("idle_wen", ram_wen, '1);
        if (lak) chk("idle_a_hold", ram_a, la);
      end
      cyc++;
    end
  end

  task automatic wait_init();
    int n = 0;
    @(negedge clk);
    while (!init_done && n < 9000) begin n++; @(negedge clk); end
    chk("init_done_cycle", n, RUN_START);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    cpurst_b = 0; p0_req = 0; p1_req = 0;
    repeat (2) @(posedge clk);
    #1 cpurst_b = 1;
    wait_init();
  endtask

  task automatic op(input bit p, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                    input logic [DW-1:0] m, output logic [DW-1:0] gw);
    bit ok = 0;
    if (p) begin p1_req = 1; p1_wr = wr; p1_addr = a; p1_wdata = d; p1_wmask = m; end
    else begin p0_req = 1; p0_wr = wr; p0_addr = a; p0_wdata = d; p0_wmask = m; end
    gw = '0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = p ? p1_gnt : p0_gnt;
      if (ok) gw = ram_wen;
      @(posedge clk); #1;
    end
    p0_req = 0; p1_req = 0;
    if (!ok) chk("op_grant_timeout", 0, 1);
  endtask

  task automatic rand_run(input int n);
    bit g0s = 1, g1s = 1;
    for (int i = 0; i < n; i++) begin
      if (!p0_req || g0s) begin
        p0_req = ($urandom % 4) != 0; p0_wr = $urandom % 2; p0_addr = AW'($urandom % 16);
        p0_wdata = rnd128(); p0_wmask = ($urandom % 2) ? '1 : rnd128();
      end
      if (!p1_req || g1s) begin
        p1_req = ($urandom % 4) != 0; p1_wr = $urandom % 2; p1_addr = AW'($urandom % 16);
        p1_wdata = rnd128(); p1_wmask = ($urandom % 2) ? '1 : rnd128();
      end
      @(negedge clk);
      g0s = p0_gnt; g1s = p1_gnt;
      @(posedge clk); #1;
    end
    p0_req = 0; p1_req = 0;
  endtask

  initial begin
    logic [DW-1:0] gw;
    cpurst_b = 0; p0_req = 0; p1_req = 0; p0_wr = 0; p1_wr = 0;
    p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = '0; p0_wmask = '0; p1_wmask = '0;
    repeat (3) @(posedge clk);
    #1 cpurst_b = 1;
    wait_init();
`ifdef CT_SPSRAM_CTRL_INIT_EN
    op(0, 0, 13'h1FFF, '0, '0, gw);
    @(negedge clk);
    chk("rd_1fff_rvld", p0_rvld, 1);
    chk("rd_1fff_data", rdata, 0);
    @(posedge clk); #1;
`endif
    op(0, 1, 13'h0A5, DEAD, '1, gw);
    op(1, 0, 13'h0A5, '0, '0, gw);
    @(negedge clk);
    chk("rd_a5_p1_rvld", p1_rvld, 1);
    chk("rd_a5_p0_rvld", p0_rvld, 0);
    chk("rd_a5_data", rdata, DEAD);
    @(posedge clk); #1;
    op(0, 1, 13'h100, '0, '1, gw);
    op(0, 1, 13'h100, '1, 128'hFF, gw);
    chk("partial_wen", gw, ~128'hFF);
    op(1, 0, 13'h100, '0, '0, gw);
    @(negedge clk);
    chk("partial_rd", rdata, 128'hFF);
    @(posedge clk); #1;
    // both clients hold read requests: grants must alternate starting with p0
    p0_req = 1; p0_wr = 0; p0_addr = 13'h0A5;
    p1_req = 1; p1_wr = 0; p1_addr = 13'h100;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("alt_p0_gnt", p0_gnt, i % 2 == 0);
      chk("alt_p1_gnt", p1_gnt, i % 2 == 1);
      if (i > 0) begin
        chk("b2b_p0_rvld", p0_rvld, i % 2 == 1);
        chk("b2b_p1_rvld", p1_rvld, i % 2 == 0);
        chk("b2b_rdata", rdata, i % 2 == 1 ? DEAD : 128'hFF);
      end
      @(posedge clk); #1;
    end
    p0_req = 0; p1_req = 0;
    @(negedge clk);
    chk("b2b_last_rvld", p1_rvld, 1);
    chk("b2b_last_data", rdata, 128'hFF);
    @(posedge clk); #1;
`ifdef CT_SPSRAM_CTRL_INIT_EN
    cpurst_b = 0;
    repeat (2) @(posedge clk);
    #1 cpurst_b = 1;
    @(negedge clk);
    for (int n = 0; n < 4001; n++) @(negedge clk);
    chk("init_cnt_4000", ram_a, 4000);
    @(posedge clk); #1;
    do_reset();
`endif
    op(0, 0, 13'h0A5, '0, '0, gw);
    chk("inflight_rvld", p0_rvld, 1);
    cpurst_b = 0;
    #1 chk("inflight_rvld_dropped", p0_rvld, 0);
    repeat (2) @(posedge clk);
    #1 cpurst_b = 1;
    wait_init();
    rand_run(3000);
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
